log_encode_pipe: RTL and testbench



---
 rtl/log_encode_pipe.sv | 113 +++++++++++
 tb/tb_log_encode_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/log_encode_pipe.sv
// Two-operand Mitchell log encoder: S1 captures operands plus leading-one position,
// S2 normalises into {k, frac}. Define LOG_ENC_ROUND_EN for round-half-up fractions.

module log_enc_lane (
  input  logic [15:0] i_x,
  input  logic [3:0]  i_k,
  output logic [15:0] o_lw
);
  logic [11:0] w_frac;

`ifdef LOG_ENC_ROUND_EN
  // Keep one guard bit below the fraction; the sum saturates rather than bumping k.
  logic [12:0] w_t;
  logic [12:0] w_sum;
  assign w_t    = 13'((i_x << (4'd15 - i_k)) >> 2);
  assign w_sum  = {1'b0, w_t[12:1]} + {12'd0, w_t[0]};
  assign w_frac = w_sum[12] ? 12'hFFF : w_sum[11:0];
`else
  assign w_frac = 12'((i_x << (4'd15 - i_k)) >> 3);
`endif

  assign o_lw = {i_k, w_frac};
endmodule

module log_encode_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_la,
  output logic [15:0] out_lb,
  output logic        out_zero
);
  localparam int NUM_LANES = 2;

  function automatic logic [3:0] f_lead(input logic [15:0] x);
    f_lead = '0;
    for (int i = 0; i < 16; i++)
      if (x[i]) f_lead = 4'(i);
  endfunction

  logic [NUM_LANES-1:0][15:0] w_x;
  logic [NUM_LANES-1:0][3:0]  w_k;
  logic [NUM_LANES-1:0]       w_z;
  logic [NUM_LANES-1:0][15:0] w_lw;

  logic                       r_s1_valid;
  logic [NUM_LANES-1:0][15:0] r_s1_x;
  logic [NUM_LANES-1:0][3:0]  r_s1_k;
  logic [NUM_LANES-1:0]       r_s1_z;
  logic                       r_s2_valid;
  logic [NUM_LANES-1:0][15:0] r_s2_lw;
  logic                       r_s2_zero;

  logic w_s1_adv, w_s2_adv;

  assign w_x = {in_b, in_a};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_k[g] = f_lead(w_x[g]);
      assign w_z[g] = (w_x[g] == 16'd0);
      // A zero operand arrives with k=0 and shifts to m=0, so its log word is 0.
      log_enc_lane u_lane (
        .i_x  (r_s1_x[g]),
        .i_k  (r_s1_k[g]),
        .o_lw (w_lw[g])
      );
    end
  endgenerate

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_k     <= '0;
      r_s1_z     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_lw    <= '0;
      r_s2_zero  <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_x <= w_x;
          r_s1_k <= w_k;
          r_s1_z <= w_z;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_lw   <= w_lw;
          r_s2_zero <= |r_s1_z;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_la    = r_s2_lw[0];
  assign out_lb    = r_s2_lw[1];
  assign out_zero  = r_s2_zero;
endmodule

// File: tb/tb_log_encode_pipe.sv
// Self-checking bench for log_encode_pipe: directed steps plus a queue-based
// scoreboard fed from an arithmetic log2 reference model.

module tb_log_encode_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_la, out_lb;
  logic        out_zero;

  int n_chk  = 0;
  int n_pass = 0;
  int n_pop  = 0;

  typedef struct { logic [15:0] la; logic [15:0] lb; logic z; } exp_t;
  exp_t q[$];

  log_encode_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_la    (out_la),
    .out_lb    (out_lb),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  // k = floor(log2 x); frac = fractional part of x/2^k scaled by 4096.
  function automatic logic [15:0] mlog(input logic [15:0] x);
    int     k;
    longint num, f;
    if (x == 16'd0) return 16'd0;
    k = 0;
    while ((x >> (k + 1)) != 0) k++;
    num = longint'(x) - (longint'(1) << k);
`ifdef LOG_ENC_ROUND_EN
    f = (((num << 13) >> k) + 1) >> 1;
    if (f > 4095) f = 4095;
`else
    f = (num << 12) >> k;
`endif
    return (16'(k) << 12) | 16'(f);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_unexpected_out", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("sb_la", out_la, e.la);
          chk("sb_lb", out_lb, e.lb);
          chk("sb_zero", out_zero, e.z);
          n_pop++;
        end
      end
      if (in_valid && in_ready) begin
        e.la = mlog(in_a);
        e.lb = mlog(in_b);
        e.z  = (in_a == 16'd0) || (in_b == 16'd0);
        q.push_back(e);
      end
    end
  end

  task automatic send_one(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ela, input logic [15:0] elb,
                          input logic ez, input string tag);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk); chk({tag, "_in_ready"}, in_ready, 1);
    tick; in_valid = 1'b0;
    @(negedge clk); chk({tag, "_lat_early"}, out_valid, 0);
    tick;
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_la"}, out_la, ela);
    chk({tag, "_lb"}, out_lb, elb);
    chk({tag, "_zero"}, out_zero, ez);
    tick;
  endtask

  initial begin
    int p0, cyc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_la", out_la, 0);
    chk("rst_out_lb", out_lb, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #3 rst_n = 1'b1;
    tick;

    send_one(16'h0001, 16'h8000, 16'h0000, 16'hF000, 1'b0, "enc0");
    send_one(16'h00C0, 16'hFFFF, 16'h7800, 16'hFFFF, 1'b0, "enc1");
    send_one(16'h0000, 16'h1234, 16'h0000, 16'hC234, 1'b1, "zero_a");
    send_one(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, "zero_ab");
`ifdef LOG_ENC_ROUND_EN
    send_one(16'h9004, 16'hFFFF, 16'hF201, 16'hFFFF, 1'b0, "round");
`else
    send_one(16'h9004, 16'h0003, 16'hF200, 16'h1800, 1'b0, "trunc");
`endif

    // Backpressure: two-deep fill, then release.
    out_ready = 1'b0;
    in_a = 16'h00C0; in_b = 16'h0001; in_valid = 1'b1;
    @(negedge clk); chk("bp_p0_ready", in_ready, 1);
    tick;
    in_a = 16'h9004; in_b = 16'h8000;
    @(negedge clk); chk("bp_p1_ready", in_ready, 1);
    tick;
    in_a = 16'h1234; in_b = 16'h00FF;
    p0 = n_pop;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_full_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_la", out_la, 16'h7800);
      tick;
    end
    out_ready = 1'b1;
    @(negedge clk); chk("bp_resume_ready", in_ready, 1);
    tick; in_valid = 1'b0;
    cyc = 0;
    while (n_pop < p0 + 3 && cyc < 10) begin tick; cyc++; end
    chk("bp_pop_count", n_pop - p0, 3);
    chk("bp_queue_empty", q.size(), 0);

    // Full-rate streaming.
    p0 = n_pop;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_a = 16'($urandom); in_b = 16'($urandom);
      @(negedge clk);
      chk("stream_ready", in_ready, 1);
      if (i >= 2) chk("stream_b2b", out_valid, 1);
      tick;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("stream_tail", out_valid, 1);
      tick;
    end
    chk("stream_pop_count", n_pop - p0, 64);

    // Random handshake toggling.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
      in_b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || out_valid) && cyc < 10) begin tick; cyc++; end
    chk("rand_drained", q.size(), 0);
    chk("rand_no_valid", out_valid, 0);

    // Asynchronous reset with both stages occupied.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'h0F00; in_b = 16'h0042;
    tick;
    in_a = 16'h7777;
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full_valid", out_valid, 1);
    chk("mid_full_ready", in_ready, 0);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_la", out_la, 0);
    chk("mid_rst_lb", out_lb, 0);
    chk("mid_rst_zero", out_zero, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    send_one(16'h0100, 16'h0003, 16'h8000, 16'h1800, 1'b0, "post_rst");
    chk("post_rst_queue", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
